// File: rtl/p18_pkg.sv
// rtl/p18_pkg.sv - shared defaults and state encoding for the line scanner
// Purpose: default geometry of the line store, scanner FSM encoding and a
//          counter-width helper shared by the scanner and its clock generator.
package p18_pkg;

    localparam int NUM_ROWS_DEF   = 15;
    localparam int LINE_WIDTH_DEF = 13;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_ADVANCE = 3'd4
    } scan_state_t;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p18_ser_clk_gen.sv
// rtl/p18_ser_clk_gen.sv - serial shift clock generator for the line scanner
// Purpose: while enable is high, produce ser_clk low for CLK_DIV cycles then
//          high for CLK_DIV cycles per bit, starting low on the first enabled cycle.
// Ports:
//   clk, nRst  - clock, asynchronous active-low reset
//   enable     - high for the whole shift window; low forces ser_clk low
//   ser_clk    - registered serial clock
//   fall_tick  - high in the last high cycle of a bit; ser_clk falls at the next edge
//   bit_done   - high when a bit period completes (same cycle as fall_tick)
module p18_ser_clk_gen
    import p18_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic nRst,
    input  logic enable,
    output logic ser_clk,
    output logic fall_tick,
    output logic bit_done
);

    localparam int CW = cnt_width(2 * CLK_DIV);
    localparam logic [CW-1:0] PHASE_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] PHASE_HIGH = CW'(CLK_DIV);

    logic [CW-1:0] phase;
    logic [CW-1:0] phase_next;

    always_comb begin
        phase_next = (phase == PHASE_LAST) ? '0 : phase + CW'(1);
    end

    // ser_clk is registered from the upcoming phase so it is glitch-free and
    // lands low again exactly when the last bit period ends.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            phase   <= '0;
            ser_clk <= 1'b0;
        end else if (enable) begin
            phase   <= phase_next;
            ser_clk <= (phase_next >= PHASE_HIGH);
        end else begin
            phase   <= '0;
            ser_clk <= 1'b0;
        end
    end

    assign fall_tick = enable && (phase == PHASE_LAST);
    assign bit_done  = enable && (phase == PHASE_LAST);

endmodule

// File: rtl/p18_line_scanner.sv
// rtl/p18_line_scanner.sv - rotating line store scanner with serial pixel output
// Purpose: for each of NUM_ROWS rows, capture the head line of the store,
//          shift it out MSB first on ser_data/ser_clk, strobe ser_latch and
//          rotate the store with next_line; frame_done marks the last row.
// Ports:
//   clk, nRst   - clock, asynchronous active-low reset
//   start       - frame request, honoured only when idle
//   hold        - store is being written; LOAD and ADVANCE stall
//   line        - head line of the rotating store
//   next_line   - one-cycle rotate pulse, never while hold is high
//   ser_data    - serial pixel data, MSB first, 0 outside shifting
//   ser_clk     - serial clock, receiver samples on the rising edge
//   ser_latch   - one-cycle strobe after each row
//   row_sel     - index of the row being shifted
//   busy        - high whenever a frame is in progress
//   frame_done  - one-cycle pulse with the final next_line of a frame
module p18_line_scanner
    import p18_pkg::*;
#(
    parameter int NUM_ROWS   = NUM_ROWS_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  start,
    input  logic                  hold,
    input  logic [LINE_WIDTH-1:0] line,
    output logic                  next_line,
    output logic                  ser_data,
    output logic                  ser_clk,
    output logic                  ser_latch,
    output logic [3:0]            row_sel,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int RW = cnt_width(NUM_ROWS);
    localparam int BW = cnt_width(LINE_WIDTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(LINE_WIDTH - 1);

    scan_state_t           state;
    logic [RW-1:0]         row_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [LINE_WIDTH-1:0] shreg;
    logic                  shift_en;
    logic                  fall_tick;
    logic                  bit_done;

    assign shift_en = (state == ST_SHIFT);

    p18_ser_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_ser_clk_gen (
        .clk       (clk),
        .nRst      (nRst),
        .enable    (shift_en),
        .ser_clk   (ser_clk),
        .fall_tick (fall_tick),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= ST_IDLE;
            row_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            row_sel <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!hold) begin
                        shreg   <= line;
                        row_sel <= 4'(row_cnt);
                        bit_cnt <= LAST_BIT;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The shift on the final fall is harmless: ser_data is
                    // gated off once the FSM leaves SHIFT.
                    if (fall_tick) begin
                        shreg <= {shreg[LINE_WIDTH-2:0], 1'b0};
                    end
                    if (bit_done) begin
                        if (bit_cnt == '0) begin
                            state <= ST_LATCH;
                        end else begin
                            bit_cnt <= bit_cnt - BW'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    state <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (!hold) begin
                        if (row_cnt == LAST_ROW) begin
                            state <= ST_IDLE;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                            state   <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // next_line must react to hold in the same cycle, so it is decoded
    // directly from the state register and the hold input.
    assign next_line  = (state == ST_ADVANCE) && !hold;
    assign frame_done = next_line && (row_cnt == LAST_ROW);
    assign ser_data   = shift_en && shreg[LINE_WIDTH-1];
    assign ser_latch  = (state == ST_LATCH);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_p18_line_scanner.sv
// tb/tb_p18_line_scanner.sv - directed self-checking bench for p18_line_scanner
module tb_p18_line_scanner;

    logic        clk = 1'b0;
    logic        nRst;
    logic        start;
    logic        hold;
    logic [12:0] line;
    logic        next_line, ser_data, ser_clk, ser_latch, busy, frame_done;
    logic [3:0]  row_sel;

    logic        start2;
    logic        hold2 = 1'b0;
    logic [12:0] line2 = 13'h1555;
    logic        next_line2, ser_data2, ser_clk2, ser_latch2, busy2, frame_done2;
    logic [3:0]  row_sel2;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    p18_line_scanner #(.NUM_ROWS(15), .LINE_WIDTH(13), .CLK_DIV(2)) dut (
        .clk(clk), .nRst(nRst), .start(start), .hold(hold), .line(line),
        .next_line(next_line), .ser_data(ser_data), .ser_clk(ser_clk),
        .ser_latch(ser_latch), .row_sel(row_sel), .busy(busy), .frame_done(frame_done)
    );

    p18_line_scanner #(.NUM_ROWS(2), .LINE_WIDTH(13), .CLK_DIV(1)) dut2 (
        .clk(clk), .nRst(nRst), .start(start2), .hold(hold2), .line(line2),
        .next_line(next_line2), .ser_data(ser_data2), .ser_clk(ser_clk2),
        .ser_latch(ser_latch2), .row_sel(row_sel2), .busy(busy2), .frame_done(frame_done2)
    );

    // Rotating line store model: head advances on every next_line.
    logic [12:0] tbl_a [15] = '{13'h1FFF, 13'h1555, 13'h0AAA, 13'h1234, 13'h0F0F,
                                13'h10F0, 13'h0001, 13'h1000, 13'h1E3C, 13'h03C7,
                                13'h1111, 13'h0EEE, 13'h1800, 13'h0003, 13'h0000};
    logic [12:0] store [15];
    logic [3:0]  head = 4'd0;
    assign line = store[head];

    // Monitor: serial receiver, pulse counters and cycle stamps.
    int          cyc = 0;
    int          nl_cnt = 0, fd_cnt = 0, latch_cnt = 0, rise_cnt = 0, viol_cnt = 0;
    int          busy_start_cyc = 0, done_cyc = 0;
    logic [12:0] rx_word = 13'd0;
    int          rx_bits = 0;
    logic [12:0] rx_words [$];
    int          rx_nbits [$];
    logic        ser_clk_prev = 1'b0, busy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!nRst) begin
                head = 4'd0;
                rx_word = 13'd0;
                rx_bits = 0;
                ser_clk_prev = 1'b0;
                busy_prev = 1'b0;
            end else begin
                if (busy && !busy_prev) busy_start_cyc = cyc;
                if (ser_clk && !ser_clk_prev) begin
                    rise_cnt++;
                    rx_word = {rx_word[11:0], ser_data};
                    rx_bits++;
                end
                if (ser_latch) begin
                    latch_cnt++;
                    rx_words.push_back(rx_word);
                    rx_nbits.push_back(rx_bits);
                    rx_word = 13'd0;
                    rx_bits = 0;
                end
                if (next_line) begin
                    nl_cnt++;
                    if (hold) viol_cnt++;
                    head = (head == 4'd14) ? 4'd0 : head + 4'd1;
                end
                if (frame_done) begin
                    fd_cnt++;
                    done_cyc = cyc;
                end
                ser_clk_prev = ser_clk;
                busy_prev = busy;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic load_table();
        for (int i = 0; i < 15; i++) store[i] = tbl_a[i];
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0; start = 1'b0; hold = 1'b0; start2 = 1'b0;
        load_table();
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if ({busy, next_line, ser_clk, ser_data, ser_latch, frame_done, row_sel} !== 10'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b, want 0", {busy, next_line, ser_clk, ser_data, ser_latch, frame_done, row_sel});
        end
        cmp_cnt++;
        if ({busy2, next_line2, ser_clk2, ser_data2, ser_latch2, frame_done2, row_sel2} !== 10'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs2: got %b, want 0", {busy2, next_line2, ser_clk2, ser_data2, ser_latch2, frame_done2, row_sel2});
        end
        @(posedge clk); #1 nRst = 1'b1;
    endtask

    task automatic test_frame(input int want_len);
        int n0, w0, fd0;
        bit ok;
        n0 = nl_cnt; w0 = rx_words.size(); fd0 = fd_cnt;
        pulse_start();
        wait_done(fd0, 2000, ok);
        cmp_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL frame_timeout: got no frame_done, want one within 2000 cycles");
        end
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (done_cyc - busy_start_cyc + 1 !== want_len) begin
            err_cnt++;
            $display("FAIL frame_len: got %0d, want %0d", done_cyc - busy_start_cyc + 1, want_len);
        end
        cmp_cnt++;
        if (nl_cnt - n0 !== 15) begin
            err_cnt++;
            $display("FAIL next_line_count: got %0d, want 15", nl_cnt - n0);
        end
        cmp_cnt++;
        if (rx_words.size() - w0 !== 15) begin
            err_cnt++;
            $display("FAIL rows_received: got %0d, want 15", rx_words.size() - w0);
        end else begin
            for (int i = 0; i < 15; i++) begin
                cmp_cnt++;
                if (rx_words[w0 + i] !== store[i] || rx_nbits[w0 + i] !== 13) begin
                    err_cnt++;
                    $display("FAIL row_data[%0d]: got %h (%0d bits), want %h (13 bits)", i, rx_words[w0 + i], rx_nbits[w0 + i], store[i]);
                end
            end
        end
        cmp_cnt++;
        if (head !== 4'd0) begin
            err_cnt++;
            $display("FAIL store_rotation: got head %0d, want 0", head);
        end
        cmp_cnt++;
        if (viol_cnt !== 0) begin
            err_cnt++;
            $display("FAIL next_line_with_hold: got %0d, want 0", viol_cnt);
        end
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL busy_after_frame: got %b, want 0", busy);
        end
    endtask

    task automatic test_pattern_1555();
        int l0, r0, w0, fd0;
        bit ok;
        load_table();
        store[0] = 13'h1555;
        fd0 = fd_cnt;
        pulse_start();
        l0 = latch_cnt; r0 = rise_cnt; w0 = rx_words.size();
        repeat (55) @(negedge clk);
        cmp_cnt++;
        if (rise_cnt - r0 !== 13) begin
            err_cnt++;
            $display("FAIL row0_rises: got %0d, want 13", rise_cnt - r0);
        end
        cmp_cnt++;
        if (latch_cnt - l0 !== 1) begin
            err_cnt++;
            $display("FAIL row0_latch: got %0d, want 1", latch_cnt - l0);
        end
        cmp_cnt++;
        if (rx_words.size() <= w0 || rx_words[w0] !== 13'h1555) begin
            err_cnt++;
            $display("FAIL row0_bits: got %h, want 1555", (rx_words.size() > w0) ? rx_words[w0] : 13'h0);
        end
        wait_done(fd0, 1000, ok);
        cmp_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL pattern_timeout: got no frame_done, want one");
        end
        repeat (3) @(negedge clk);
        load_table();
    endtask

    task automatic test_hold();
        int seen, fd0, n0;
        bit ok;
        fd0 = fd_cnt; n0 = nl_cnt; seen = 0;
        pulse_start();
        for (int i = 0; i < 500 && seen < 4; i++) begin
            @(negedge clk);
            if (ser_latch) seen++;
        end
        hold = 1'b1;
        repeat (6) @(posedge clk);
        #1 hold = 1'b0;
        wait_done(fd0, 2000, ok);
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (!ok || done_cyc - busy_start_cyc + 1 !== 830) begin
            err_cnt++;
            $display("FAIL hold_frame_len: got %0d, want 830", done_cyc - busy_start_cyc + 1);
        end
        cmp_cnt++;
        if (viol_cnt !== 0) begin
            err_cnt++;
            $display("FAIL hold_next_line: got %0d coincident pulses, want 0", viol_cnt);
        end
        cmp_cnt++;
        if (nl_cnt - n0 !== 15) begin
            err_cnt++;
            $display("FAIL hold_next_line_count: got %0d, want 15", nl_cnt - n0);
        end
    endtask

    task automatic test_start_ignored();
        int fd0;
        bit ok;
        fd0 = fd_cnt;
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        wait_done(fd0, 2000, ok);
        repeat (60) @(negedge clk);
        cmp_cnt++;
        if (fd_cnt - fd0 !== 1) begin
            err_cnt++;
            $display("FAIL start_while_busy_done: got %0d frames, want 1", fd_cnt - fd0);
        end
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_while_busy_queued: got busy %b, want 0", busy);
        end
        // start presented in the frame_done cycle must not relaunch
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_at_done: got busy %b, want 0", busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int seen, n0;
        seen = 0;
        pulse_start();
        for (int i = 0; i < 1000 && seen < 7; i++) begin
            @(negedge clk);
            if (ser_latch) seen++;
        end
        repeat (20) @(negedge clk);
        cmp_cnt++;
        if (row_sel !== 4'd7) begin
            err_cnt++;
            $display("FAIL mid_row_sel: got %0d, want 7", row_sel);
        end
        n0 = nl_cnt;
        #2 nRst = 1'b0;
        #1;
        cmp_cnt++;
        if ({busy, next_line, ser_clk, ser_data, ser_latch, frame_done, row_sel} !== 10'd0) begin
            err_cnt++;
            $display("FAIL mid_reset_outputs: got %b, want 0", {busy, next_line, ser_clk, ser_data, ser_latch, frame_done, row_sel});
        end
        repeat (3) @(negedge clk);
        cmp_cnt++;
        if (nl_cnt - n0 !== 0) begin
            err_cnt++;
            $display("FAIL mid_reset_next_line: got %0d, want 0", nl_cnt - n0);
        end
        @(posedge clk); #1 nRst = 1'b1;
        test_frame(825);
    endtask

    task automatic test_clkdiv1();
        int t_busy, r1, r2, l1, l2, t_done, rises;
        logic pc;
        t_busy = -1; r1 = -1; r2 = -1; l1 = -1; l2 = -1; t_done = -1; rises = 0; pc = 1'b0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy2 && t_busy < 0) t_busy = i;
            if (ser_clk2 && !pc) begin
                rises++;
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            pc = ser_clk2;
            if (ser_latch2) begin
                if (l1 < 0) l1 = i;
                else l2 = i;
            end
            if (frame_done2) begin
                t_done = i;
                break;
            end
        end
        cmp_cnt++;
        if (t_done < 0 || t_done - t_busy + 1 !== 58) begin
            err_cnt++;
            $display("FAIL div1_frame_len: got %0d, want 58", t_done - t_busy + 1);
        end
        cmp_cnt++;
        if (l2 - l1 !== 29) begin
            err_cnt++;
            $display("FAIL div1_row_len: got %0d, want 29", l2 - l1);
        end
        cmp_cnt++;
        if (r2 - r1 !== 2) begin
            err_cnt++;
            $display("FAIL div1_clk_period: got %0d, want 2", r2 - r1);
        end
        cmp_cnt++;
        if (rises !== 26) begin
            err_cnt++;
            $display("FAIL div1_rises: got %0d, want 26", rises);
        end
    endtask

    initial begin
        test_reset();
        test_frame(825);
        test_pattern_1555();
        test_hold();
        test_start_ignored();
        test_reset_mid_frame();
        test_clkdiv1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/p18_line_scanner.md
P18_LINE_SCANNER -- requirements
Module: p18_line_scanner

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_ROWS, 15, rows per frame in the line store; LINE_WIDTH, 13, bits per line; CLK_DIV, 2, clk cycles per serial-clock half period (min 1).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- nRst, in, 1, reset, asynchronous, active-low.
- start, in, 1, frame request; honoured only in IDLE.
- hold, in, 1, store is being written this cycle; scanner stalls.
- line, in, LINE_WIDTH, current head line of the rotating line store.
- next_line, out, 1, one-cycle pulse that rotates the store by one row.
- ser_data, out, 1, serial pixel data, MSB (bit LINE_WIDTH-1) first.
- ser_clk, out, 1, serial shift clock; the receiver samples on the rising edge.
- ser_latch, out, 1, one-cycle strobe after each row's bits.
- row_sel, out, 4, index of the row being shifted, 0..NUM_ROWS-1.
- busy, out, 1, high in every state except IDLE.
- frame_done, out, 1, one-cycle pulse at end of frame.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, SHIFT, LATCH, ADVANCE.
REQ-004 IDLE: start=1 SHALL move to LOAD next cycle, clear row counter.
REQ-005 LOAD: if hold=0, SHALL capture line into shift register, set row_sel=row counter, reset bit counter to LINE_WIDTH-1, go to SHIFT; if hold=1, SHALL remain in LOAD.
REQ-006 SHIFT: ser_data SHALL equal shift-register MSB; ser_clk SHALL be low CLK_DIV cycles then high CLK_DIV cycles per bit; register shifts left on each high-to-low transition.
REQ-007 SHIFT SHALL last exactly LINE_WIDTH*2*CLK_DIV cycles, then go to LATCH with ser_clk low; hold SHALL be ignored in SHIFT.
REQ-008 LATCH: ser_latch=1 for exactly one cycle, then ADVANCE.
REQ-009 ADVANCE: if hold=0, next_line=1 for exactly one cycle; if row counter == NUM_ROWS-1, frame_done=1 in the same cycle and go to IDLE, else increment row counter and go to LOAD; if hold=1, SHALL remain in ADVANCE with next_line=0.
REQ-010 Per-row length with no hold SHALL be 3 + LINE_WIDTH*2*CLK_DIV cycles (55 at defaults); frame = NUM_ROWS times that (825).
REQ-011 A full frame SHALL issue exactly NUM_ROWS next_line pulses, returning the store to its original rotation.
REQ-012 next_line SHALL never be asserted while hold=1.
REQ-013 start while busy SHALL be ignored (not queued); start in the frame_done cycle SHALL be ignored.
REQ-014 ser_data SHALL be 0 and ser_clk 0 outside SHIFT.
REQ-015 Row counter SHALL be ceil(log2(NUM_ROWS)) bits, zero-extended onto row_sel; no wrap beyond NUM_ROWS-1.

Reset
REQ-016 nRst low SHALL asynchronously force IDLE, row counter 0, shift register 0, and all outputs 0 (row_sel=0, busy=0).
REQ-017 Reset mid-frame SHALL abandon the frame without further next_line pulses; store realignment is the system's responsibility.

Structure
REQ-018 A shared package p18_pkg SHALL hold NUM_ROWS, LINE_WIDTH defaults and the scanner state encoding.
REQ-019 Serial clock timing SHALL live in one sub-module p18_ser_clk_gen (enable in, ser_clk out, fall-edge tick out, bit_done tick out).

Verification
REQ-020 Bench SHALL cover:
- start pulse, line model = rows 0x1FFF..0x0000 as a 15-deep rotating store -> 15 rows of 13 bits received MSB first matching the store, 15 next_line pulses, frame_done at cycle 825 after LOAD entry.
- line=0x1555 on row 0 -> ser_data sequence 1,0,1,0,...,1 sampled on 13 ser_clk rising edges, ser_latch once.
- hold=1 for 5 cycles at entry to ADVANCE of row 3 -> next_line delayed 5 cycles, never coincident with hold, frame length 830.
- start re-pulsed at cycle 100 while busy -> ignored; exactly one frame_done.
- nRst low during SHIFT of row 7 -> all outputs 0 immediately, IDLE; subsequent start runs a full clean frame.
- CLK_DIV=1, LINE_WIDTH=13 -> row length 29 cycles, ser_clk period 2 cycles.
